// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one unified memory port between an instruction
// cache and a data cache, serving one latched request at a time.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_req,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_req,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  hold_wen_q,   hold_wen_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q,  hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;

    logic grant_i;
    logic grant_d;
    logic busy;

    // On a tie the client that was not served last wins.
    assign grant_i = i_req && (!d_req || (last_grant_q == GRANT_D));
    assign grant_d = d_req && (!i_req || (last_grant_q == GRANT_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_wen_d   = hold_wen_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = BUSY_I;
                    last_grant_d = GRANT_I;
                    hold_wen_d   = i_wen;
                    hold_addr_d  = i_addr;
                    hold_wdata_d = i_wdata;
                end else if (grant_d) begin
                    state_d      = BUSY_D;
                    last_grant_d = GRANT_D;
                    hold_wen_d   = d_wen;
                    hold_addr_d  = d_addr;
                    hold_wdata_d = d_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            hold_wen_q   <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_wen_q   <= hold_wen_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    // Memory side sees only the holding registers, and only while a transaction is open.
    assign busy      = (state_q != IDLE);
    assign mem_req   = busy;
    assign mem_wen   = busy && hold_wen_q;
    assign mem_addr  = busy ? hold_addr_q  : '0;
    assign mem_wdata = busy ? hold_wdata_q : '0;

    assign i_ready = (state_q == BUSY_I) && mem_ready;
    assign d_ready = (state_q == BUSY_D) && mem_ready;
    assign i_rdata = i_ready ? mem_rdata : '0;
    assign d_rdata = d_ready ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every address port.
REQ-002 Parameter DATA_WIDTH, default 32, width of every data port.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction-cache memory request, held high until i_ready.
REQ-006 i_wen  input  1  instruction-cache write enable (1 = write, 0 = read).
REQ-007 i_addr  input  ADDR_WIDTH  instruction-cache word address.
REQ-008 i_wdata  input  DATA_WIDTH  instruction-cache write data.
REQ-009 i_ready  output  1  one-cycle pulse: instruction transaction complete.
REQ-010 i_rdata  output  DATA_WIDTH  read data for the instruction cache, valid only while i_ready=1.
REQ-011 d_req, d_wen, d_addr, d_wdata, d_ready, d_rdata: data-cache port, same directions, widths and meanings as REQ-005..REQ-010.
REQ-012 mem_req  output  1  request to the unified main memory.
REQ-013 mem_wen  output  1  memory write enable.
REQ-014 mem_addr  output  ADDR_WIDTH  memory address.
REQ-015 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-016 mem_rdata  input  DATA_WIDTH  memory read data, valid while mem_ready=1.
REQ-017 mem_ready  input  1  memory completion, sampled only while mem_req=1.

Function
REQ-018 FSM has exactly three states: IDLE, BUSY_I, BUSY_D.
REQ-019 IDLE, only i_req=1: latch i_wen/i_addr/i_wdata into holding registers and go to BUSY_I.
REQ-020 IDLE, only d_req=1: latch the d_* fields and go to BUSY_D.
REQ-021 IDLE, both requests: grant the client not in last_grant (round-robin); last_grant resets to D, so I wins the first tie.
REQ-022 IDLE, no request: remain in IDLE; mem_req=0.
REQ-023 last_grant updates to the granted client on every IDLE-to-BUSY transition.
REQ-024 In BUSY_x, mem_req=1 and mem_wen/mem_addr/mem_wdata are driven from the holding registers only, never from live client inputs.
REQ-025 In BUSY_x with mem_ready=0: hold state and all memory outputs stable.
REQ-026 In BUSY_x with mem_ready=1: x_ready=1 in that same cycle, x_rdata=mem_rdata (combinational pass-through), and the next state is IDLE.
REQ-027 Only the served client sees ready; the other client's ready=0 and its rdata=0.
REQ-028 x_rdata=0 whenever x_ready=0.
REQ-029 For a write, x_ready still pulses and x_rdata equals mem_rdata (content undefined to the client).
REQ-030 Minimum latency: request seen in IDLE at cycle N, mem_req high at N+1, earliest x_ready at N+1.
REQ-031 Every transaction returns through IDLE, so there is one idle cycle between consecutive memory transactions.
REQ-032 A client that drops req while BUSY on it does not abort the transaction; the memory transaction completes and ready still pulses.
REQ-033 A request from the other client during BUSY is not latched; it is considered at the next IDLE cycle.
REQ-034 mem_ready while IDLE is ignored; no ready is produced.

Reset
REQ-035 Asserting reset in any state, mid-transaction included, immediately forces IDLE, last_grant=D, and clears the holding registers.
REQ-036 While reset=1: mem_req, mem_wen, mem_addr, mem_wdata, i_ready, d_ready, i_rdata and d_rdata are all 0.
REQ-037 An in-flight transaction cut by reset is not resumed and produces no ready pulse.

Verification
REQ-038 Single read: i_req=1, i_addr=0x100, i_wen=0, memory ready after 3 BUSY cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100 from cycle N+1; i_ready=1 and i_rdata=0xDEADBEEF only at N+3; d_ready stays 0.
REQ-039 Tie after reset: i_req=d_req=1 held -> I served first, then D, then I; grants alternate with one IDLE cycle between transactions.
REQ-040 Write hold: d_req=1, d_wen=1, d_addr=0x200, d_wdata=0x12345678; client changes d_addr to 0x300 while BUSY -> mem_addr stays 0x200 and mem_wdata stays 0x12345678 until mem_ready.
REQ-041 Zero-wait memory: mem_ready tied to 1 and d_req held -> d_ready pulses every second cycle.
REQ-042 Reset mid-transaction: reset pulsed in BUSY_I -> mem_req=0 immediately, no i_ready; after release, a tie grants I.
REQ-043 Stray mem_ready in IDLE with no requests -> i_ready=d_ready=0 and the state stays IDLE.
